// File: rtl/csa_seq_wide_adder_if.sv
// Request/result bundle between a host and csa_seq_wide_adder.
// The sub field exists only when CSA_SEQ_SUB_EN is defined.
interface csa_seq_wide_adder_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef CSA_SEQ_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
`ifdef CSA_SEQ_SUB_EN
    output sub,
`endif
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
`ifdef CSA_SEQ_SUB_EN
    input  sub,
`endif
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/csa_seq_wide_adder.sv
// Sequential wide adder: one shared 4-bit carry-select slice walks nibbles LSB->MSB.
// Optional subtract mode enabled by defining CSA_SEQ_SUB_EN.
module csa_seq_wide_adder #(
  parameter int NIBBLES = 4
) (
  input logic                   clk,
  input logic                   rst,
  csa_seq_wide_adder_if.slave   bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);

  // Carry-select slice: both carry-in outcomes are formed, the real carry picks one.
  function automatic logic [4:0] csa4(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] s0;
    logic [4:0] s1;
    s0 = {1'b0, x} + {1'b0, y};
    s1 = {1'b0, x} + {1'b0, y} + 5'd1;
    return c ? s1 : s0;
  endfunction

  logic [1:0]    state_r;
  logic [IW-1:0] idx_r;
  logic          carry_r;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  sum_r;
  logic          cout_r;
  logic          ovf_r;
  logic          busy_r;
  logic          done_r;

  logic [W-1:0]  b_eff_s;
  logic          cin_eff_s;
  logic [3:0]    a_nibs_s [NIBBLES];
  logic [3:0]    b_nibs_s [NIBBLES];
  logic [3:0]    a_nib_s;
  logic [3:0]    b_nib_s;
  logic [4:0]    slice_s;
  logic          last_s;

`ifdef CSA_SEQ_SUB_EN
  assign b_eff_s   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff_s = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff_s   = bus.b;
  assign cin_eff_s = bus.cin;
`endif

  for (genvar g = 0; g < NIBBLES; g++) begin : g_nib
    assign a_nibs_s[g] = a_r[4*g +: 4];
    assign b_nibs_s[g] = b_r[4*g +: 4];
  end

  assign a_nib_s = a_nibs_s[idx_r];
  assign b_nib_s = b_nibs_s[idx_r];
  assign slice_s = csa4(a_nib_s, b_nib_s, carry_r);
  assign last_s  = (idx_r == IDX_LAST);

  // Control FSM, operand latches and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {IW{1'b0}};
      carry_r <= 1'b0;
      a_r     <= {W{1'b0}};
      b_r     <= {W{1'b0}};
      sum_r   <= {W{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= b_eff_s;
            carry_r <= cin_eff_s;
            idx_r   <= {IW{1'b0}};
            sum_r   <= {W{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
            busy_r  <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx_r == IW'(i)) begin
              sum_r[4*i +: 4] <= slice_s[3:0];
            end
          end
          carry_r <= slice_s[4];
          if (last_s) begin
            // Signed overflow: operands agree in sign but the result does not.
            cout_r  <= slice_s[4];
            ovf_r   <= (a_r[W-1] == b_r[W-1]) && (slice_s[3] != a_r[W-1]);
            idx_r   <= {IW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            idx_r   <= idx_r + IDX_ONE;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_csa_seq_wide_adder.sv
// Self-checking bench for csa_seq_wide_adder (NIBBLES=4 and NIBBLES=1 instances).
// Expected results come from plain wide-integer arithmetic on the operands.
module tb_csa_seq_wide_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  csa_seq_wide_adder_if #(.NIBBLES(4)) bus  ();
  csa_seq_wide_adder_if #(.NIBBLES(1)) bus1 ();

  csa_seq_wide_adder #(.NIBBLES(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  csa_seq_wide_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for done on the 4-nibble instance; lat = negedges after accept - 1.
  task automatic wait_done(output int lat, output int bc);
    lat = -1;
    bc  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.busy) bc++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb);
    logic [15:0] be;
    logic        ce;
    logic [16:0] full;
    logic        eovf;
    int          lat;
    int          bc;
    be   = sb ? ~b : b;
    ce   = sb ? 1'b1 : ci;
    full = {1'b0, a} + {1'b0, be} + {16'd0, ce};
    eovf = (a[15] == be[15]) && (full[15] != a[15]);
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.cin = ci;
`ifdef CSA_SEQ_SUB_EN
    bus.sub = sb;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a = 16'($urandom); bus.b = 16'($urandom); bus.cin = 1'($urandom);
`ifdef CSA_SEQ_SUB_EN
    bus.sub = 1'($urandom);
`endif
    wait_done(lat, bc);
    check({tag, "_lat"},  lat, 32'd4);
    check({tag, "_busy"}, bc, 32'd4);
    check({tag, "_sum"},  bus.sum, full[15:0]);
    check({tag, "_cout"}, bus.cout, full[16]);
    check({tag, "_ovf"},  bus.ovf, eovf);
    @(negedge clk);
    check({tag, "_pulse"}, bus.done, 1'b0);
    check({tag, "_hold"},  bus.sum, full[15:0]);
  endtask

  task automatic do_op1(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] full;
    int         lat;
    full = {1'b0, a} + {1'b0, b} + {4'd0, ci};
    @(negedge clk);
    bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = ci;
    @(posedge clk); #1;
    bus1.start = 1'b0;
    lat = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus1.done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_lat"},  lat, 32'd1);
    check({tag, "_sum"},  bus1.sum, full[3:0]);
    check({tag, "_cout"}, bus1.cout, full[4]);
    check({tag, "_ovf"},  bus1.ovf, (a[3] == b[3]) && (full[3] != a[3]));
  endtask

  initial begin
    int   lat;
    int   bc;
    bit   seen;
    logic sb;

    bus.start = 1'b0;  bus.a = 16'd0;  bus.b = 16'd0;  bus.cin = 1'b0;
    bus1.start = 1'b0; bus1.a = 4'd0;  bus1.b = 4'd0;  bus1.cin = 1'b0;
`ifdef CSA_SEQ_SUB_EN
    bus.sub = 1'b0; bus1.sub = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_sum",  bus.sum, 16'd0);
    check("rst_cout", bus.cout, 1'b0);
    check("rst_ovf",  bus.ovf, 1'b0);
    check("rst1_sum", bus1.sum, 4'd0);
    rst = 1'b0;

    do_op("basic",  16'h1234, 16'h4321, 1'b0, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    do_op("ovfpos", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    do_op("cinin",  16'h00FF, 16'h0F00, 1'b1, 1'b0);
    do_op("ovfneg", 16'h8000, 16'h8000, 1'b0, 1'b0);
`ifdef CSA_SEQ_SUB_EN
    do_op("sub_a", 16'h0005, 16'h0007, 1'b0, 1'b1);
    do_op("sub_b", 16'h8000, 16'h0001, 1'b0, 1'b1);
`endif

    // Start during RUN is ignored; start held during done launches a new op.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0;
`ifdef CSA_SEQ_SUB_EN
    bus.sub = 1'b0;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'hAAAA; bus.b = 16'h0000;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat, bc);
    check("ign_lat", lat, 32'd1);
    check("ign_sum", bus.sum, 16'h0002);
    bus.start = 1'b1; bus.a = 16'h0F0F; bus.b = 16'h0101; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bc);
    check("b2b_lat",  lat, 32'd4);
    check("b2b_busy", bc, 32'd4);
    check("b2b_sum",  bus.sum, 16'h1010);

    // Reset mid-RUN aborts without a done pulse.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1111; bus.b = 16'h1111; bus.cin = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_sum",  bus.sum, 16'd0);
    check("abort_cout", bus.cout, 1'b0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check("abort_nodone", seen, 1'b0);

    do_op1("n1_fixed", 4'hF, 4'h1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      do_op1("n1_rand", 4'($urandom), 4'($urandom), 1'($urandom));
    end

    for (int k = 0; k < 20; k++) begin
`ifdef CSA_SEQ_SUB_EN
      sb = 1'($urandom);
`else
      sb = 1'b0;
`endif
      do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), sb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
